nps_inmem: RTL and testbench

Input-side frame memory for the NPS streaming pipeline. The CPU writes a frame of DATA_WIDTH words into local storage and programs the frame length. On `start`, the block replays the frame as a vo/fo/datao stream into the downstream processing chain. It is the source-end counterpart of the output capture memory: its stream output follows the same vi/fi/data convention that the capture memory consumes.

---
 rtl/nps_inmem_if.sv | 41 ++++
 rtl/nps_inmem.sv | 152 +++++++++++++++
 tb/tb_nps_inmem.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/nps_inmem_if.sv
// CPU bus and playback stream bundle for nps_inmem.
// NPS_INMEM_READBACK_EN adds the cpu_rd / cpu_rdata readback pair.
interface nps_inmem_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADR_WIDTH  = 9
);
  logic                  start;
  logic                  set;
  logic [ADR_WIDTH-1:0]  cpu_adr;
  logic [DATA_WIDTH-1:0] cpu_data;
  logic                  cpu_wr;
  logic                  vo;
  logic                  fo;
  logic [DATA_WIDTH-1:0] datao;
  logic                  busy;
  logic                  done;
`ifdef NPS_INMEM_READBACK_EN
  logic                  cpu_rd;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  modport slave (
    input  start, set, cpu_adr, cpu_data, cpu_wr, cpu_rd,
    output vo, fo, datao, busy, done, cpu_rdata
  );

  modport master (
    output start, set, cpu_adr, cpu_data, cpu_wr, cpu_rd,
    input  vo, fo, datao, busy, done, cpu_rdata
  );
`else
  modport slave (
    input  start, set, cpu_adr, cpu_data, cpu_wr,
    output vo, fo, datao, busy, done
  );

  modport master (
    output start, set, cpu_adr, cpu_data, cpu_wr,
    input  vo, fo, datao, busy, done
  );
`endif
endinterface

// File: rtl/nps_inmem.sv
// Input-side frame memory: CPU fills a frame, `start` replays it as a vo/fo/datao stream.
// Optional CPU readback port is enabled with NPS_INMEM_READBACK_EN.
module nps_inmem #(
  parameter int DATA_WIDTH = 24,
  parameter int DATA_NUM   = 300,
  parameter int ADR_WIDTH  = 9
) (
  input  logic         clk,
  input  logic         reset_x,
  nps_inmem_if.slave   bus
);

  localparam logic [ADR_WIDTH:0] LP_ZERO     = {(ADR_WIDTH+1){1'b0}};
  localparam logic [ADR_WIDTH:0] LP_ONE      = {{ADR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADR_WIDTH:0] LP_DATA_NUM = (ADR_WIDTH+1)'(DATA_NUM);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_start_acc;
  logic                  w_rd_en;
  logic                  w_last;
  logic                  w_set_acc;
  logic                  w_adr_ok;
  logic [ADR_WIDTH:0]    w_len_req;
  logic [ADR_WIDTH:0]    w_len_clip;
  logic [ADR_WIDTH-1:0]  w_rd_idx;

  logic [DATA_WIDTH-1:0] r_mem [0:DATA_NUM-1];
  logic [ADR_WIDTH:0]    r_len;
  logic [ADR_WIDTH:0]    r_rd_adr;
  logic                  r_vo;
  logic                  r_fo;
  logic [DATA_WIDTH-1:0] r_datao;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_last;

  // rd_adr stays below len (<= DATA_NUM), so its low bits always index a real word
  assign w_rd_idx   = r_rd_adr[ADR_WIDTH-1:0];
  assign w_last     = (r_rd_adr == (r_len - LP_ONE));
  assign w_adr_ok   = ({1'b0, bus.cpu_adr} < LP_DATA_NUM);
  assign w_set_acc  = (r_state == ST_IDLE) && bus.set;
  assign w_len_req  = bus.cpu_data[ADR_WIDTH:0];
  assign w_len_clip = (w_len_req > LP_DATA_NUM) ? LP_DATA_NUM : w_len_req;

  // FSM state register
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and per-cycle strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && (r_len != LP_ZERO)) begin
          w_state_nxt = ST_RUN;
          w_start_acc = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_rd_en = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame storage; a same-cycle playback read sees the old word
  always_ff @(posedge clk) begin
    if (bus.cpu_wr && w_adr_ok) begin
      r_mem[bus.cpu_adr] <= bus.cpu_data;
    end
  end

  // Playback datapath, stream flags, busy/done and frame length
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_len    <= LP_ZERO;
      r_rd_adr <= LP_ZERO;
      r_vo     <= 1'b0;
      r_fo     <= 1'b0;
      r_datao  <= {DATA_WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_vo   <= 1'b0;
      r_fo   <= 1'b0;
      r_done <= r_last;
      r_last <= 1'b0;
      if (w_set_acc) begin
        r_len <= w_len_clip;
      end
      if (w_start_acc) begin
        r_rd_adr <= LP_ZERO;
        r_busy   <= 1'b1;
      end
      if (w_rd_en) begin
        r_datao  <= r_mem[w_rd_idx];
        r_vo     <= 1'b1;
        r_fo     <= (r_rd_adr == LP_ZERO);
        r_rd_adr <= r_rd_adr + LP_ONE;
        if (w_last) begin
          r_busy <= 1'b0;
          r_last <= 1'b1;
        end
      end
    end
  end

  assign bus.vo    = r_vo;
  assign bus.fo    = r_fo;
  assign bus.datao = r_datao;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

`ifdef NPS_INMEM_READBACK_EN
  logic [DATA_WIDTH-1:0] r_cpu_rdata;

  // CPU readback, one-cycle latency, zero for out-of-range addresses
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_cpu_rdata <= {DATA_WIDTH{1'b0}};
    end else if (bus.cpu_rd) begin
      r_cpu_rdata <= w_adr_ok ? r_mem[bus.cpu_adr] : {DATA_WIDTH{1'b0}};
    end
  end

  assign bus.cpu_rdata = r_cpu_rdata;
`endif

endmodule

// File: tb/tb_nps_inmem.sv
// Directed self-checking bench for nps_inmem; inputs driven and outputs sampled on the falling edge.
module tb_nps_inmem;

  localparam int DW = 24;
  localparam int DN = 300;
  localparam int AW = 9;

  logic clk     = 1'b0;
  logic reset_x = 1'b0;
  always #5 clk = ~clk;

  nps_inmem_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) bus ();

  nps_inmem #(.DATA_WIDTH(DW), .DATA_NUM(DN), .ADR_WIDTH(AW)) u_dut (
    .clk     (clk),
    .reset_x (reset_x),
    .bus     (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [DW-1:0] cap_data [0:15];
  int          nvo;
  int          n_done;
  logic [63:0] vo_m, fo_m, done_m, busy_m;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.set      = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_adr  = '0;
    bus.cpu_data = '0;
`ifdef NPS_INMEM_READBACK_EN
    bus.cpu_rd   = 1'b0;
`endif
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_wr = 1'b1; bus.cpu_adr = a; bus.cpu_data = d;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic set_len(input logic [DW-1:0] v);
    bus.set = 1'b1; bus.cpu_data = v;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  // 1: start+set(2) in RUN, 2: mem[3]=ABCDEF, 3: start, 4: mem[1]=999999
  task automatic inject(input int kind);
    case (kind)
      1: begin bus.start = 1'b1; bus.set = 1'b1; bus.cpu_data = 24'd2; end
      2: begin bus.cpu_wr = 1'b1; bus.cpu_adr = 9'd3; bus.cpu_data = 24'hABCDEF; end
      3: begin bus.start = 1'b1; end
      4: begin bus.cpu_wr = 1'b1; bus.cpu_adr = 9'd1; bus.cpu_data = 24'h999999; end
      default: begin end
    endcase
  endtask

  // Cycle c is observed after edge k+c when start was taken at edge k
  task automatic capture(input int ncyc, input int c1, input int k1, input int c2, input int k2);
    nvo = 0; n_done = 0;
    vo_m = '0; fo_m = '0; done_m = '0; busy_m = '0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == c1) inject(k1);
      if (c == c2) inject(k2);
      @(negedge clk);
      idle_inputs();
      if (bus.vo === 1'b1) begin
        if (nvo < 16) cap_data[nvo] = bus.datao;
        nvo++;
      end
      if (bus.done === 1'b1) n_done++;
      if (c < 64) begin
        vo_m[c] = bus.vo; fo_m[c] = bus.fo; done_m[c] = bus.done; busy_m[c] = bus.busy;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    repeat (2) @(negedge clk);
    check_eq("rst_vo", bus.vo, 0);
    check_eq("rst_fo", bus.fo, 0);
    check_eq("rst_datao", bus.datao, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    reset_x = 1'b1;
    @(negedge clk);

    // basic 4-word frame
    cpu_write(9'd0, 24'h000011);
    cpu_write(9'd1, 24'h000022);
    cpu_write(9'd2, 24'h000033);
    cpu_write(9'd3, 24'h000044);
    set_len(24'd4);
    pulse_start();
    check_eq("t1_busy_k", bus.busy, 1);
    check_eq("t1_vo_k", bus.vo, 0);
    capture(7, 0, 0, 0, 0);
    check_eq("t1_nvo", nvo, 4);
    check_eq("t1_w0", cap_data[0], 24'h11);
    check_eq("t1_w1", cap_data[1], 24'h22);
    check_eq("t1_w2", cap_data[2], 24'h33);
    check_eq("t1_w3", cap_data[3], 24'h44);
    check_eq("t1_vo_mask", vo_m, 64'h1E);
    check_eq("t1_fo_mask", fo_m, 64'h2);
    check_eq("t1_done_mask", done_m, 64'h20);
    check_eq("t1_busy_mask", busy_m, 64'hE);

    // zero length is ignored, oversize length clips to DATA_NUM
    set_len(24'd0);
    pulse_start();
    check_eq("t2_busy_k", bus.busy, 0);
    capture(6, 0, 0, 0, 0);
    check_eq("t2_nvo0", nvo, 0);
    check_eq("t2_done0", n_done, 0);
    check_eq("t2_busy0", busy_m, 0);
    set_len(24'd500);
    pulse_start();
    capture(310, 0, 0, 0, 0);
    check_eq("t2_nvo300", nvo, 300);
    check_eq("t2_done300", n_done, 1);

    // start+set during RUN ignored; next start at first IDLE edge
    set_len(24'd4);
    pulse_start();
    capture(11, 1, 1, 5, 3);
    check_eq("t3_nvo", nvo, 8);
    check_eq("t3_vo_mask", vo_m, 64'h3DE);
    check_eq("t3_fo_mask", fo_m, 64'h42);
    check_eq("t3_done_mask", done_m, 64'h420);
    check_eq("t3_f2_w0", cap_data[4], 24'h11);
    check_eq("t3_f2_w3", cap_data[7], 24'h44);

    // writes during playback: ahead of the reader vs behind it
    pulse_start();
    capture(6, 3, 2, 4, 4);
    check_eq("t4_nvo", nvo, 4);
    check_eq("t4_w1_old", cap_data[1], 24'h22);
    check_eq("t4_w3_new", cap_data[3], 24'hABCDEF);
    pulse_start();
    capture(6, 0, 0, 0, 0);
    check_eq("t4_next_w1", cap_data[1], 24'h999999);
    check_eq("t4_next_w3", cap_data[3], 24'hABCDEF);

    // asynchronous reset mid-frame
    pulse_start();
    repeat (3) @(negedge clk);
    check_eq("t5_vo_w2", bus.vo, 1);
    check_eq("t5_datao_w2", bus.datao, 24'h33);
    reset_x = 1'b0;
    #1;
    check_eq("t5_rst_vo", bus.vo, 0);
    check_eq("t5_rst_fo", bus.fo, 0);
    check_eq("t5_rst_busy", bus.busy, 0);
    check_eq("t5_rst_done", bus.done, 0);
    check_eq("t5_rst_datao", bus.datao, 0);
    @(negedge clk);
    reset_x = 1'b1;
    @(negedge clk);
    pulse_start();
    check_eq("t5_nolen_busy", bus.busy, 0);
    capture(6, 0, 0, 0, 0);
    check_eq("t5_nolen_nvo", nvo, 0);
    check_eq("t5_nolen_done", done_m, 0);
    set_len(24'd4);
    pulse_start();
    capture(6, 0, 0, 0, 0);
    check_eq("t5_reset_nvo", nvo, 4);
    check_eq("t5_reset_w1", cap_data[1], 24'h999999);

`ifdef NPS_INMEM_READBACK_EN
    cpu_write(9'd7, 24'h123456);
    bus.cpu_rd = 1'b1; bus.cpu_adr = 9'd7;
    @(negedge clk);
    idle_inputs();
    check_eq("rb_adr7", bus.cpu_rdata, 24'h123456);
    bus.cpu_rd = 1'b1; bus.cpu_adr = 9'd310;
    @(negedge clk);
    idle_inputs();
    check_eq("rb_adr310", bus.cpu_rdata, 0);
    bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_adr = 9'd7; bus.cpu_data = 24'h654321;
    @(negedge clk);
    idle_inputs();
    check_eq("rb_rdwr_old", bus.cpu_rdata, 24'h123456);
    bus.cpu_rd = 1'b1; bus.cpu_adr = 9'd7;
    @(negedge clk);
    idle_inputs();
    check_eq("rb_rdwr_new", bus.cpu_rdata, 24'h654321);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
